// File: rtl/jump_pkg.sv
// jump_pkg: shared types and defaults for the jump_judge game controller.
package jump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PLAY,
    SETTLE,
    WIN,
    LOSE
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int DEFAULT_COURSE_LEN     = 33;
  localparam int DEFAULT_MAX_MISSES     = 3;
  localparam int DEFAULT_TIMEOUT_CYCLES = 50_000_000;

endpackage

// File: rtl/jump_judge_sync_edge.sv
// sync_edge: brings an asynchronous level into the clk domain through two
// flops and flags its rising edge for exactly one cycle.
module sync_edge
  import jump_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic prev;

  // Two-flop synchronizer followed by a previous-value flop for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;

endmodule

// File: rtl/jump_judge.sv
// jump_judge: judges left/right key presses against the box direction coming
// out of the course shift register, drives its load/advance strobes and keeps
// the step and miss score. Defining JUMP_TIMEOUT_EN adds a per-step time limit
// of TIMEOUT_CYCLES clocks that counts as a miss when it runs out.
module jump_judge
  import jump_pkg::*;
#(
  parameter int COURSE_LEN     = DEFAULT_COURSE_LEN,
  parameter int MAX_MISSES     = DEFAULT_MAX_MISSES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       box_dir,
  output logic       load_n,
  output logic       advance,
  output logic [5:0] steps,
  output logic [1:0] misses,
  output logic       playing,
  output logic       win,
  output logic       lose
);

  localparam logic [5:0] STEPS_MAX  = 6'(COURSE_LEN);
  localparam logic [1:0] MISSES_MAX = 2'(MAX_MISSES);

  state_t     state;
  state_t     state_next;
  logic [5:0] steps_next;
  logic [1:0] misses_next;
  logic       advance_next;
  logic       hit;
  logic       miss;
  logic       left_evt;
  logic       right_evt;
  logic       start_evt;
  logic       timeout_evt;
  logic       pressed_dir;
  logic [6:0] steps_inc;
  logic [2:0] misses_inc;

  sync_edge u_sync_left (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (key_left),
    .rise    (left_evt)
  );

  sync_edge u_sync_right (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (key_right),
    .rise    (right_evt)
  );

  sync_edge u_sync_start (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (start),
    .rise    (start_evt)
  );

  assign pressed_dir = right_evt ? DIR_RIGHT : DIR_LEFT;
  assign steps_inc   = 7'(steps) + 7'd1;
  assign misses_inc  = 3'(misses) + 3'd1;

`ifdef JUMP_TIMEOUT_EN
  localparam int TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic               key_evt;
  logic [TIMER_W-1:0] timer;

  assign key_evt = left_evt | right_evt;

  // Per-step countdown: parked at reload outside PLAY, restarted by any key or expiry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer <= TIMER_RELOAD;
    end else if ((state != PLAY) || key_evt || (timer == '0)) begin
      timer <= TIMER_RELOAD;
    end else begin
      timer <= timer - TIMER_W'(1);
    end
  end

  assign timeout_evt = (state == PLAY) && (timer == '0);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_evt    = 1'b0;
`endif

  // State, score and advance strobe registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      steps   <= '0;
      misses  <= '0;
      advance <= 1'b0;
    end else begin
      state   <= state_next;
      steps   <= steps_next;
      misses  <= misses_next;
      advance <= advance_next;
    end
  end

  // Game sequencing and judging of key events against the current box
  always_comb begin
    state_next   = state;
    steps_next   = steps;
    misses_next  = misses;
    advance_next = 1'b0;
    hit          = 1'b0;
    miss         = 1'b0;
    case (state)
      IDLE: begin
        if (start_evt) state_next = LOAD;
      end
      LOAD: begin
        steps_next  = '0;
        misses_next = '0;
        state_next  = PLAY;
      end
      PLAY: begin
        if (start_evt) begin
          state_next = LOAD;
        end else if (left_evt && right_evt) begin
          miss = 1'b1;
        end else if (left_evt || right_evt) begin
          if (pressed_dir == box_dir) hit = 1'b1;
          else                        miss = 1'b1;
        end else if (timeout_evt) begin
          miss = 1'b1;
        end
        if (hit) begin
          advance_next = 1'b1;
          if (steps_inc >= {1'b0, STEPS_MAX}) begin
            steps_next = STEPS_MAX;
            state_next = WIN;
          end else begin
            steps_next = steps_inc[5:0];
            state_next = SETTLE;
          end
        end
        if (miss) begin
          if (misses_inc >= {1'b0, MISSES_MAX}) begin
            misses_next = MISSES_MAX;
            state_next  = LOSE;
          end else begin
            misses_next = misses_inc[1:0];
          end
        end
      end
      SETTLE: begin
        state_next = start_evt ? LOAD : PLAY;
      end
      WIN, LOSE: begin
        if (start_evt) state_next = LOAD;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign load_n  = (state != LOAD);
  assign playing = (state == PLAY) || (state == SETTLE);
  assign win     = (state == WIN);
  assign lose    = (state == LOSE);

endmodule

// File: tb/tb_jump_judge.sv
// tb_jump_judge: self-checking bench for jump_judge. Emulates the course
// shift register, keeps a cycle-level game model, and runs table vectors,
// hand-written corner sequences and a randomized session.
module tb_jump_judge;

  localparam int COURSE = 33;
  localparam int MAXM   = 3;
  localparam int TO     = 10;

  localparam int M_WAIT    = 0;
  localparam int M_LOADING = 1;
  localparam int M_RUN     = 2;
  localparam int M_COOL    = 3;
  localparam int M_WON     = 4;
  localparam int M_LOST    = 5;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       key_left;
  logic       key_right;
  logic       box_dir;
  logic       load_n;
  logic       advance;
  logic [5:0] steps;
  logic [1:0] misses;
  logic       playing;
  logic       win;
  logic       lose;

  int checks = 0;
  int errors = 0;

  bit course [0:63];
  int pos;

  int cyc = 0;
  int adv_count = 0;
  int last_adv_cyc = -1;

  int       m_mode;
  int       m_steps;
  int       m_misses;
  int       m_quiet;
  bit       m_adv;
  bit [3:0] hl;
  bit [3:0] hr;
  bit [3:0] hs;

  typedef struct {
    string name;
    bit    kl;
    bit    kr;
    int    exp_steps;
    int    exp_misses;
    bit    exp_lose;
  } vec_t;

  jump_judge #(
    .COURSE_LEN     (COURSE),
    .MAX_MISSES     (MAXM),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .key_left  (key_left),
    .key_right (key_right),
    .box_dir   (box_dir),
    .load_n    (load_n),
    .advance   (advance),
    .steps     (steps),
    .misses    (misses),
    .playing   (playing),
    .win       (win),
    .lose      (lose)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Course shift register stand-in: load_n rewinds it, advance moves to the next box
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos = 0;
      box_dir <= course[0];
    end else begin
      if (!load_n) pos = 0;
      else if (advance && pos < 63) pos = pos + 1;
      box_dir <= course[pos];
    end
  end

  // Game model: keys take effect two edges after first being sampled high
  always @(posedge clk) begin
    bit evl, evr, evs, hit, miss;
    logic [12:0] exp_v, act_v;
    cyc++;
    if (!reset_n) begin
      m_mode = M_WAIT; m_steps = 0; m_misses = 0; m_quiet = 0; m_adv = 0;
      hl = '0; hr = '0; hs = '0;
    end else begin
      hl = {hl[2:0], key_left};
      hr = {hr[2:0], key_right};
      hs = {hs[2:0], start};
      evl = hl[2] & ~hl[3];
      evr = hr[2] & ~hr[3];
      evs = hs[2] & ~hs[3];
      hit = 0; miss = 0; m_adv = 0;
      case (m_mode)
        M_WAIT: if (evs) m_mode = M_LOADING;
        M_LOADING: begin
          m_steps = 0; m_misses = 0; m_quiet = 0; m_mode = M_RUN;
        end
        M_RUN: begin
          if (evs) m_mode = M_LOADING;
          else if (evl || evr) begin
            m_quiet = 0;
            if (evl != evr && evr == course[m_steps]) hit = 1;
            else miss = 1;
          end
`ifdef JUMP_TIMEOUT_EN
          else if (m_quiet == TO - 1) begin
            miss = 1; m_quiet = 0;
          end else m_quiet++;
`endif
          if (hit) begin
            m_steps++; m_adv = 1;
            m_mode = (m_steps == COURSE) ? M_WON : M_COOL;
          end
          if (miss) begin
            m_misses++;
            if (m_misses == MAXM) m_mode = M_LOST;
          end
        end
        M_COOL: begin
          m_mode = evs ? M_LOADING : M_RUN;
          m_quiet = 0;
        end
        default: if (evs) m_mode = M_LOADING;
      endcase
    end
    #1;
    exp_v = {m_mode != M_LOADING, m_adv, 6'(m_steps), 2'(m_misses),
             m_mode == M_RUN || m_mode == M_COOL, m_mode == M_WON, m_mode == M_LOST};
    act_v = {load_n, advance, steps, misses, playing, win, lose};
    checkOutput("model_outputs", 32'(act_v), 32'(exp_v));
    if (advance) begin
      adv_count++;
      last_adv_cyc = cyc;
    end
  end

  task automatic applyStimulus(input bit kl, input bit kr, input bit st, input int hold, input int gap);
    @(negedge clk);
    key_left = kl; key_right = kr; start = st;
    repeat (hold) @(negedge clk);
    key_left = 0; key_right = 0; start = 0;
    repeat (gap - 1) @(negedge clk);
  endtask

  // Pulses start and watches the load strobe and the entry into play
  task automatic start_game();
    int lows = 0;
    @(negedge clk);
    start = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = 0;
      if (!load_n) lows++;
    end
    checkOutput("load_n_low_cycles", 32'(lows), 32'd1);
    checkOutput("playing_after_load", 32'(playing), 32'd1);
    checkOutput("steps_after_load", 32'(steps), 32'd0);
    checkOutput("misses_after_load", 32'(misses), 32'd0);
  endtask

  task automatic set_course(input int kind);
    for (int i = 0; i < 64; i++) begin
      case (kind)
        0: course[i] = 1'b0;
        1: course[i] = 1'b1;
        2: course[i] = i[0];
        default: course[i] = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  initial begin
    vec_t vecs [7];
    int   a0, k0;

    vecs[0] = '{"wrong_right_on_left", 0, 1, 0, 1, 0};
    vecs[1] = '{"left_on_left",        1, 0, 1, 1, 0};
    vecs[2] = '{"right_on_right",      0, 1, 2, 1, 0};
    vecs[3] = '{"both_keys",           1, 1, 2, 2, 0};
    vecs[4] = '{"left_on_left_2",      1, 0, 3, 2, 0};
    vecs[5] = '{"left_on_right_lose",  1, 0, 3, 3, 1};
    vecs[6] = '{"key_after_lose",      0, 1, 3, 3, 1};

    reset_n = 0; start = 0; key_left = 0; key_right = 0;
    set_course(0);
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", 32'({load_n, advance, steps, misses, playing, win, lose}),
                32'(13'b1_0_000000_00_000));
    reset_n = 1;
    repeat (2) @(negedge clk);

    $display("[TB] correct press, advance timing, press during settle");
    set_course(1);
    start_game();
    a0 = adv_count;
    @(negedge clk);
    k0 = cyc;
    key_right = 1;
    @(negedge clk);
    key_left = 1;
    @(negedge clk);
    key_left = 0; key_right = 0;
    repeat (5) @(negedge clk);
    checkOutput("advance_pulses", 32'(adv_count - a0), 32'd1);
    checkOutput("advance_edge", 32'(last_adv_cyc), 32'(k0 + 3));
    checkOutput("steps_one", 32'(steps), 32'd1);
    checkOutput("settle_key_ignored", 32'(misses), 32'd0);

    $display("[TB] three wrong presses lose");
    set_course(0);
    start_game();
    a0 = adv_count;
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(0, 1, 0, 1, 4);
      checkOutput("miss_count", 32'(misses), 32'(i));
    end
    checkOutput("lose_level", 32'(lose), 32'd1);
    applyStimulus(1, 0, 0, 1, 4);
    checkOutput("misses_held", 32'(misses), 32'd3);
    checkOutput("no_advance_on_miss", 32'(adv_count - a0), 32'd0);

    $display("[TB] table vectors");
    set_course(2);
    start_game();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].kl, vecs[i].kr, 0, 2, 4);
      checkOutput({vecs[i].name, "_steps"}, 32'(steps), 32'(vecs[i].exp_steps));
      checkOutput({vecs[i].name, "_misses"}, 32'(misses), 32'(vecs[i].exp_misses));
      checkOutput({vecs[i].name, "_lose"}, 32'(lose), 32'(vecs[i].exp_lose));
    end

    $display("[TB] full course win");
    set_course(3);
    start_game();
    a0 = adv_count;
    for (int i = 0; i < COURSE; i++) applyStimulus(!course[i], course[i], 0, 1, 4);
    checkOutput("win_advances", 32'(adv_count - a0), 32'(COURSE));
    checkOutput("win_steps", 32'(steps), 32'(COURSE));
    checkOutput("win_level", 32'(win), 32'd1);
    checkOutput("win_not_playing", 32'(playing), 32'd0);
    start_game();

`ifdef JUMP_TIMEOUT_EN
    $display("[TB] timeout");
    set_course(1);
    start_game();
    repeat (7) @(negedge clk);
    checkOutput("timeout_not_yet", 32'(misses), 32'd0);
    @(negedge clk);
    checkOutput("timeout_miss", 32'(misses), 32'd1);
    repeat (7) @(negedge clk);
    key_right = 1;
    @(negedge clk);
    key_right = 0;
    repeat (2) @(negedge clk);
    checkOutput("expiry_key_advance", 32'(advance), 32'd1);
    checkOutput("expiry_key_misses", 32'(misses), 32'd1);
    checkOutput("expiry_key_steps", 32'(steps), 32'd1);
`endif

    $display("[TB] reset mid-game");
    set_course(1);
    start_game();
    applyStimulus(0, 1, 0, 1, 2);
    @(negedge clk);
    #2;
    reset_n = 0;
    #1;
    checkOutput("async_reset_outputs", 32'({load_n, advance, steps, misses, playing, win, lose}),
                32'(13'b1_0_000000_00_000));
    repeat (2) @(negedge clk);
    reset_n = 1;
    repeat (4) @(negedge clk);
    checkOutput("idle_after_reset", 32'({load_n, advance, playing}), 32'(3'b100));

    $display("[TB] randomized session");
    set_course(3);
    start_game();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      key_left  = ($urandom_range(0, 3) == 0);
      key_right = ($urandom_range(0, 3) == 0);
      start     = ($urandom_range(0, 149) == 0);
    end
    @(negedge clk);
    key_left = 0; key_right = 0; start = 0;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
